multicycle_control: RTL
=======================

# multicycle_control

Multi-cycle main control unit for the RISC-V core. It replaces the purely combinational opcode decoder with a state machine that sequences fetch, decode, execute, memory and writeback over several cycles. It handshakes with a shared instruction/data memory that may insert wait states, traps illegal opcodes and memory timeouts, and counts retired instructions. It sits between the instruction register and the datapath muxes, ALU control, register file and memory port.

## Interface
Parameters:
- MEM_TIMEOUT, 64: max wait cycles for mem_ready per request; 0 disables the timeout.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- opcode  in  7  instr[6:0] from the IR; sampled only in S_DECODE.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request valid.
- mem_read, mem_write  out  1  request type (fetch counts as a read).
- ir_write  out  1  load the IR from memory data.
- pc_write  out  1  update the PC; the target is selected by branch/jump (PC+4 when both are 0).
- mem_to_reg, reg_write  out  1  writeback source select and register-file write enable.
- alu_src_1  out  1  0=RS1, 1=PC.
- alu_src_2  out  1  0=RS2, 1=IMM.
- out_sel  out  1  0=ALU, 1=IMM.
- branch, jump  out  1  PC-target select; branch is conditional, taken only on the ALU zero flag in the datapath.
- alu_op  out  2  ADD=00, BRANCH=01, OP=10, OP_IMM=11.
- retire  out  1  one-cycle pulse per completed instruction.
- instret  out  CNT_W  retired-instruction count.
- trap  out  1  sticky fault flag.
- trap_cause  out  2  00=none, 01=illegal opcode, 10=memory timeout.

## Operation
- States: S_RESET, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP.
- Outputs are Moore: decoded from the registered state and the opcode register `op_q`, which is captured in S_DECODE.
- **S_RESET:** all outputs 0; always goes to S_FETCH next cycle.
- **S_FETCH:**
  - Drives mem_req=1, mem_read=1.
  - On mem_ready: ir_write=1 in that same cycle, then go to S_DECODE.
- **S_DECODE:** latch op_q.
  - Legal opcodes: LOAD, OP_IMM, AUIPC, STORE, OP, LUI, BRANCH, JALR, JAL. These go to S_EXEC.
  - Any other opcode goes to S_TRAP with cause 01.
- **S_EXEC:** ALU controls per op_q.
  - LOAD/STORE: RS1+IMM, ADD.
  - OP_IMM: RS1, IMM, OP_IMM.
  - OP: RS1, RS2, OP.
  - AUIPC: PC+IMM, ADD.
  - LUI: out_sel=IMM.
  - BRANCH: RS1, RS2, BRANCH, branch=1, pc_write=1, retire; go to S_FETCH.
  - JAL: PC+IMM. JALR: RS1+IMM. Both assert jump=1, pc_write=1, then go to S_WB.
  - LOAD/STORE go to S_MEM; all others go to S_WB.
- **S_MEM:**
  - Drives mem_req=1 with mem_read (LOAD) or mem_write (STORE); ALU controls are held from S_EXEC.
  - On mem_ready: LOAD goes to S_WB; STORE asserts pc_write, retire and goes to S_FETCH.
- **S_WB:** reg_write=1, retire=1, then S_FETCH.
  - mem_to_reg=1 only for LOAD.
  - pc_write=1 except for JAL/JALR, whose PC was already written in S_EXEC. In those cases the link value is PC+4 via the datapath.
- **Timeout:**
  - wait_cnt is cleared on entry to S_FETCH/S_MEM and on mem_ready; otherwise it increments while mem_req=1 and mem_ready=0.
  - When wait_cnt==MEM_TIMEOUT (with MEM_TIMEOUT≠0), go to S_TRAP with cause 10. This takes priority over a mem_ready arriving in the same cycle.
- **S_TRAP:** trap=1, all other control outputs 0; held until rst.
- **instret:** increments by 1 on each retire; wraps modulo 2^CNT_W.

## Timing
- Reset values: state=S_RESET, op_q=0, wait_cnt=0, instret=0, trap=0, trap_cause=00; every output is 0.
- Reset asserted mid-instruction aborts immediately (asynchronous). Any in-flight request is dropped; mem_req falls in the same cycle.
- First mem_req is asserted in the 2nd cycle after reset deasserts.
- Cycle counts with zero-wait memory (mem_ready high in the request cycle):
  - BRANCH: 3.
  - OP, OP_IMM, LUI, AUIPC, JAL, JALR, STORE: 4.
  - LOAD: 5.
- Each wait cycle adds 1 cycle in S_FETCH or S_MEM.
- retire fires in exactly one cycle per instruction. pc_write coincides with retire, except for JAL/JALR, where it is in S_EXEC.
- mem_req/mem_read/mem_write stay stable until the cycle in which mem_ready is sampled high.

## Structure
- Shared package `ctl_pkg`:
  - opcode constants (OPCODE_*);
  - CTL_ALU_* alu_op codes;
  - CTL_ALU_1_*, CTL_ALU_2_*, CTL_ALU/CTL_IMM mux codes;
  - state enum;
  - trap-cause codes.
- Sub-module `opcode_classify`: combinational. Maps opcode to legal, is_load, is_store, is_branch, is_jump, is_auipc and the ALU-control triple. The FSM uses it for both decode and output generation.

## Test plan
- Zero-wait `add x3,x1,x2` (opcode 0110011): 4 cycles.
  - S_EXEC: alu_src_2=0, alu_op=10.
  - S_WB: reg_write=1, retire=1; instret goes 0→1.
- LOAD with mem_ready low for 3 cycles in S_MEM: 8 cycles total; mem_read held throughout; mem_to_reg=1 in S_WB.
- Opcode 0000000 (illegal): trap=1 and trap_cause=01 two cycles after the fetch completes. Further mem_ready is ignored; instret is unchanged.
- MEM_TIMEOUT=4 with mem_ready never asserted during fetch: trap_cause=10 after 4 wait cycles. A simultaneous mem_ready on that cycle still traps.
- JAL: pc_write=1 with jump=1 in S_EXEC, then reg_write=1 with pc_write=0 in S_WB. BRANCH: retire in S_EXEC, 3 cycles.
- CNT_W=4, 16 OP instructions: instret wraps 15→0. Reset asserted in S_MEM of a STORE: mem_write drops immediately, and one cycle after deassert the FSM restarts at S_FETCH.

Source files
------------

// File: rtl/ctl_pkg.sv
// ---------------------------------------------------------------------------
// ctl_pkg
// Shared definitions for the multi-cycle RISC-V main control unit:
//   - RV32I major opcode constants (OPCODE_*)
//   - ALU operation codes driven on alu_op (CTL_ALU_*)
//   - operand / result mux select codes (CTL_ALU_1_*, CTL_ALU_2_*, CTL_ALU, CTL_IMM)
//   - controller state enum and trap-cause codes
// ---------------------------------------------------------------------------
package ctl_pkg;

    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

    localparam logic [1:0] CTL_ALU_ADD    = 2'b00;
    localparam logic [1:0] CTL_ALU_BRANCH = 2'b01;
    localparam logic [1:0] CTL_ALU_OP     = 2'b10;
    localparam logic [1:0] CTL_ALU_OP_IMM = 2'b11;

    localparam logic CTL_ALU_1_RS1 = 1'b0;
    localparam logic CTL_ALU_1_PC  = 1'b1;
    localparam logic CTL_ALU_2_RS2 = 1'b0;
    localparam logic CTL_ALU_2_IMM = 1'b1;
    localparam logic CTL_ALU       = 1'b0;
    localparam logic CTL_IMM       = 1'b1;

    typedef enum logic [2:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } ctl_state_t;

    typedef enum logic [1:0] {
        TRAP_NONE    = 2'b00,
        TRAP_ILLEGAL = 2'b01,
        TRAP_TIMEOUT = 2'b10
    } trap_cause_t;

endpackage

// File: rtl/multicycle_control_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_if
// Bundle between the main control unit and the rest of the core.
//   opcode, mem_ready          : into the controller (IR opcode, memory done)
//   mem_req/read/write         : memory request and type
//   ir_write, pc_write         : IR / PC load enables
//   mem_to_reg, reg_write      : writeback source and register-file enable
//   alu_src_1/2, alu_op        : ALU operand selects and operation class
//   out_sel, branch, jump      : result select and PC-target select
//   retire, instret            : retirement pulse and counter
//   trap, trap_cause           : sticky fault flag and its reason
// master = controller side, slave = datapath/memory side.
// ---------------------------------------------------------------------------
interface multicycle_control_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       opcode;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             pc_write;
    logic             mem_to_reg;
    logic             reg_write;
    logic             alu_src_1;
    logic             alu_src_2;
    logic             out_sel;
    logic             branch;
    logic             jump;
    logic [1:0]       alu_op;
    logic             retire;
    logic [CNT_W-1:0] instret;
    logic             trap;
    logic [1:0]       trap_cause;

    modport master (
        input  opcode, mem_ready,
        output mem_req, mem_read, mem_write, ir_write, pc_write,
               mem_to_reg, reg_write, alu_src_1, alu_src_2, out_sel,
               branch, jump, alu_op, retire, instret, trap, trap_cause
    );

    modport slave (
        output opcode, mem_ready,
        input  mem_req, mem_read, mem_write, ir_write, pc_write,
               mem_to_reg, reg_write, alu_src_1, alu_src_2, out_sel,
               branch, jump, alu_op, retire, instret, trap, trap_cause
    );
endinterface

// File: rtl/opcode_classify.sv
// ---------------------------------------------------------------------------
// opcode_classify
// Combinational opcode classifier.
//   opcode     in  7 : major opcode
//   legal         out: opcode is one of the nine supported classes
//   is_load/is_store/is_branch/is_jump(JAL or JALR)/is_auipc : class flags
//   alu_src_1, alu_src_2, alu_op : ALU-control triple for this opcode
//   out_sel    out   : result select (IMM only for LUI)
// ---------------------------------------------------------------------------
module opcode_classify
    import ctl_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       legal,
    output logic       is_load,
    output logic       is_store,
    output logic       is_branch,
    output logic       is_jump,
    output logic       is_auipc,
    output logic       alu_src_1,
    output logic       alu_src_2,
    output logic [1:0] alu_op,
    output logic       out_sel
);

    // Unknown opcodes fall through with everything deasserted, so only
    // the legal flag is needed to detect them.
    always_comb begin
        legal     = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_jump   = 1'b0;
        is_auipc  = 1'b0;
        alu_src_1 = CTL_ALU_1_RS1;
        alu_src_2 = CTL_ALU_2_RS2;
        alu_op    = CTL_ALU_ADD;
        out_sel   = CTL_ALU;
        case (opcode)
            OPCODE_LOAD: begin
                legal     = 1'b1;
                is_load   = 1'b1;
                alu_src_2 = CTL_ALU_2_IMM;
            end
            OPCODE_STORE: begin
                legal     = 1'b1;
                is_store  = 1'b1;
                alu_src_2 = CTL_ALU_2_IMM;
            end
            OPCODE_OP_IMM: begin
                legal     = 1'b1;
                alu_src_2 = CTL_ALU_2_IMM;
                alu_op    = CTL_ALU_OP_IMM;
            end
            OPCODE_OP: begin
                legal  = 1'b1;
                alu_op = CTL_ALU_OP;
            end
            OPCODE_AUIPC: begin
                legal     = 1'b1;
                is_auipc  = 1'b1;
                alu_src_1 = CTL_ALU_1_PC;
                alu_src_2 = CTL_ALU_2_IMM;
            end
            OPCODE_LUI: begin
                legal   = 1'b1;
                out_sel = CTL_IMM;
            end
            OPCODE_BRANCH: begin
                legal     = 1'b1;
                is_branch = 1'b1;
                alu_op    = CTL_ALU_BRANCH;
            end
            OPCODE_JAL: begin
                legal     = 1'b1;
                is_jump   = 1'b1;
                alu_src_1 = CTL_ALU_1_PC;
                alu_src_2 = CTL_ALU_2_IMM;
            end
            OPCODE_JALR: begin
                legal     = 1'b1;
                is_jump   = 1'b1;
                alu_src_2 = CTL_ALU_2_IMM;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Multi-cycle main control FSM: fetch -> decode -> execute -> [memory] ->
// [writeback], with memory wait-state handshake, illegal-opcode and
// memory-timeout traps, and a retired-instruction counter.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : multicycle_control_if.master (see interface for signal list)
// Parameters:
//   MEM_TIMEOUT : wait cycles tolerated per memory request (0 = never trap)
//   CNT_W       : width of instret
// ---------------------------------------------------------------------------
module multicycle_control
    import ctl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input logic                  clk,
    input logic                  rst,
    multicycle_control_if.master bus
);

    localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    ctl_state_t         state;
    logic [6:0]         op_q;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]   instret_q;
    trap_cause_t        trap_cause_q;

    logic [6:0] cls_opcode;
    logic       legal;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_jump;
    logic       is_auipc_unused;
    logic       cls_src_1;
    logic       cls_src_2;
    logic [1:0] cls_alu_op;
    logic       cls_out_sel;

    logic       timeout;
    logic       mem_done;

    logic       mem_req;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_1;
    logic       alu_src_2;
    logic       out_sel;
    logic       branch;
    logic       jump;
    logic [1:0] alu_op;
    logic       retire;
    logic       trap;

    // One classifier serves both jobs: in S_DECODE it looks at the live
    // IR opcode to decide legality; everywhere else it decodes op_q.
    // AUIPC needs nothing beyond its ALU triple, so its flag is not used.
    assign cls_opcode = (state == S_DECODE) ? bus.opcode : op_q;

    opcode_classify u_classify (
        .opcode    (cls_opcode),
        .legal     (legal),
        .is_load   (is_load),
        .is_store  (is_store),
        .is_branch (is_branch),
        .is_jump   (is_jump),
        .is_auipc  (is_auipc_unused),
        .alu_src_1 (cls_src_1),
        .alu_src_2 (cls_src_2),
        .alu_op    (cls_alu_op),
        .out_sel   (cls_out_sel)
    );

    // A timeout beats a mem_ready arriving in the same cycle, so the
    // request only counts as done when the timeout has not fired.
    assign timeout  = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_W'(MEM_TIMEOUT));
    assign mem_done = bus.mem_ready && !timeout;

    // State register, opcode latch, wait counter, retire counter and trap
    // cause. wait_cnt is zeroed on every path into S_FETCH / S_MEM and on a
    // completed request, and only grows while a request is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_RESET;
            op_q         <= '0;
            wait_cnt     <= '0;
            instret_q    <= '0;
            trap_cause_q <= TRAP_NONE;
        end else begin
            if (retire) begin
                instret_q <= instret_q + CNT_W'(1);
            end
            case (state)
                S_RESET: begin
                    wait_cnt <= '0;
                    state    <= S_FETCH;
                end
                S_FETCH, S_MEM: begin
                    if (timeout) begin
                        state        <= S_TRAP;
                        trap_cause_q <= TRAP_TIMEOUT;
                    end else if (bus.mem_ready) begin
                        wait_cnt <= '0;
                        if (state == S_FETCH) begin
                            state <= S_DECODE;
                        end else if (is_load) begin
                            state <= S_WB;
                        end else begin
                            state <= S_FETCH;
                        end
                    end else if (MEM_TIMEOUT != 0) begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_DECODE: begin
                    op_q <= bus.opcode;
                    if (legal) begin
                        state <= S_EXEC;
                    end else begin
                        state        <= S_TRAP;
                        trap_cause_q <= TRAP_ILLEGAL;
                    end
                end
                S_EXEC: begin
                    wait_cnt <= '0;
                    if (is_load || is_store) begin
                        state <= S_MEM;
                    end else if (is_branch) begin
                        state <= S_FETCH;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_WB: begin
                    wait_cnt <= '0;
                    state    <= S_FETCH;
                end
                S_TRAP: begin
                    state <= S_TRAP;
                end
                default: begin
                    state <= S_RESET;
                end
            endcase
        end
    end

    // Control outputs decoded from the registered state and op_q. Only the
    // handshake-completion strobes (ir_write, store retire) also look at
    // mem_ready. Reset clears state asynchronously, so every output, in
    // particular mem_req, drops as soon as rst rises.
    always_comb begin
        mem_req    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_1  = CTL_ALU_1_RS1;
        alu_src_2  = CTL_ALU_2_RS2;
        out_sel    = CTL_ALU;
        branch     = 1'b0;
        jump       = 1'b0;
        alu_op     = CTL_ALU_ADD;
        retire     = 1'b0;
        trap       = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_read = 1'b1;
                ir_write = mem_done;
            end
            S_EXEC: begin
                alu_src_1 = cls_src_1;
                alu_src_2 = cls_src_2;
                alu_op    = cls_alu_op;
                out_sel   = cls_out_sel;
                if (is_branch) begin
                    branch   = 1'b1;
                    pc_write = 1'b1;
                    retire   = 1'b1;
                end
                if (is_jump) begin
                    jump     = 1'b1;
                    pc_write = 1'b1;
                end
            end
            S_MEM: begin
                alu_src_1 = cls_src_1;
                alu_src_2 = cls_src_2;
                alu_op    = cls_alu_op;
                mem_req   = 1'b1;
                mem_read  = is_load;
                mem_write = is_store;
                if (is_store && mem_done) begin
                    pc_write = 1'b1;
                    retire   = 1'b1;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                retire     = 1'b1;
                mem_to_reg = is_load;
                pc_write   = !is_jump;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.mem_req    = mem_req;
    assign bus.mem_read   = mem_read;
    assign bus.mem_write  = mem_write;
    assign bus.ir_write   = ir_write;
    assign bus.pc_write   = pc_write;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.reg_write  = reg_write;
    assign bus.alu_src_1  = alu_src_1;
    assign bus.alu_src_2  = alu_src_2;
    assign bus.out_sel    = out_sel;
    assign bus.branch     = branch;
    assign bus.jump       = jump;
    assign bus.alu_op     = alu_op;
    assign bus.retire     = retire;
    assign bus.instret    = instret_q;
    assign bus.trap       = trap;
    assign bus.trap_cause = trap_cause_q;

endmodule
